// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter in front of one shared WIDTH-bit register.
// An ARB cycle picks a winner and the following ACCESS cycle performs its read/optional write.
// Each access returns the register's pre-access value on rdata.
//
// Ports:
//   clock  - sole clock, rising edge
//   reset  - synchronous, active-high
//   req    - per-requester level request, held until granted
//   we     - per-requester write enable, only honoured for the granted requester
//   wdata  - packed write data, requester i drives [i*WIDTH +: WIDTH]
//   grant  - one-hot (or zero) access strobe, high during the ACCESS cycle
//   rdata  - register value read by the most recent completed access
//   value  - current register contents
//   busy   - high while in ACCESS
module reg_share_arbiter #(
  parameter int unsigned     N_REQ = 4,
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(7)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       we,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       grant,
  output logic [WIDTH-1:0]       rdata,
  output logic [WIDTH-1:0]       value,
  output logic                   busy
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {StArb, StAccess} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    last_q, win_q, pick;
  logic [WIDTH-1:0] reg_q, rdata_q, wsel;
  logic             access_ok;

  // Round-robin search starting just after the last completed winner.
  always_comb begin
    logic          found;
    logic [IW-1:0] cand_idx;
    int            cand;
    found    = 1'b0;
    pick     = '0;
    cand_idx = '0;
    cand     = 0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand     = (int'(last_q) + k) % int'(N_REQ);
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // Write-data slice of the current winner.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (IW'(i) == win_q) wsel = wdata[i*WIDTH +: WIDTH];
    end
  end

  // A winner that dropped req before its ACCESS cycle is cancelled; reset also aborts.
  assign access_ok = (state_q == StAccess) && req[win_q] && !reset;

  always_comb begin
    state_d = state_q;
    grant   = '0;
    unique case (state_q)
      StArb:    if (|req) state_d = StAccess;
      StAccess: begin
        state_d = StArb;
        if (access_ok) grant[win_q] = 1'b1;
      end
      default:  state_d = StArb;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StArb;
      last_q  <= IW'(N_REQ - 1);
      win_q   <= '0;
      reg_q   <= INIT;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StArb && |req) win_q <= pick;
      if (access_ok) begin
        rdata_q <= reg_q;
        last_q  <= win_q;
        if (we[win_q]) reg_q <= wsel;
      end
    end
  end

  assign rdata = rdata_q;
  assign value = reg_q;
  assign busy  = (state_q == StAccess);

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter that shares a single WIDTH-bit state register among N_REQ requesters. Each granted access returns the register's pre-access value and may overwrite it. A two-state FSM alternates an arbitration cycle with an access cycle. The block sits between client modules and a shared configuration/state register whose power-on value is INIT (7 by default).

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register and data width
- INIT, 7, register value after reset

Ports (one clock; reset is synchronous and active-high):
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- req  input  N_REQ  per-requester access request; level, held until grant
- we  input  N_REQ  per-requester write enable, qualified by grant
- wdata  input  N_REQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
- grant  output  N_REQ  one-hot (or zero) access strobe, one cycle
- rdata  output  WIDTH  register value read by the most recent completed access
- value  output  WIDTH  current register contents
- busy  output  1  high while the FSM is in ACCESS

## Operation
- FSM states: ARB and ACCESS. Reset state is ARB.
- ARB:
  - If req is zero, stay in ARB.
  - Otherwise pick the winner by searching from (last+1) mod N_REQ upward with wrap. Register winner into win_q and go to ACCESS.
- ACCESS, when req[win_q] is still high:
  - grant[win_q]=1.
  - rdata <= register (pre-write value).
  - If we[win_q], register <= wdata slice win_q.
  - last <= win_q.
  - Return to ARB.
- ACCESS, when req[win_q] has dropped:
  - Access is cancelled: grant stays 0, no write, rdata and last unchanged.
  - Return to ARB.
- Requests from non-winners during ACCESS are ignored and re-evaluated in the next ARB.
- we and wdata of non-granted requesters are ignored.
- last resets to N_REQ-1, so requester 0 has first priority after reset.
- Arithmetic: the pointer wraps modulo N_REQ. The register is a plain WIDTH-bit store with no arithmetic.
- Reset values:
  - grant=0, rdata=0, busy=0, value=INIT
  - FSM=ARB, last=N_REQ-1, win_q=0
- Reset asserted during ACCESS aborts the access: no write, no grant. All reset values apply on the next cycle.

## Timing
- Cycle t (ARB): req is sampled.
- Cycle t+1 (ACCESS): grant[winner] is high and busy is high. grant is combinational from state, win_q and req.
- Cycle t+2:
  - rdata shows the pre-write value.
  - value shows the written data if we was set.
- Peak throughput: one access per 2 cycles. With continuous requests, grants appear on alternating cycles.
- Fairness: with all N_REQ requesting continuously, each requester is granted exactly once per 2*N_REQ cycles.
- A requester whose req drops and re-rises is re-arbitrated with no stored priority.
- grant is never asserted in ARB and never has more than one bit set.

## Test plan
- Reset, then idle:
  - value=7, rdata=0, grant=0, busy=0 on every cycle.
  - FSM stays in ARB with req=0.
- Single read:
  - req=4'b0010 held, we=0 → grant=4'b0010 on the 2nd cycle after req.
  - rdata=7 on the following cycle; value stays 7.
- Write then read:
  - Requester 3 writes 8'hA5 → value=8'hA5 one cycle after grant, rdata=7.
  - Requester 0 then reads → rdata=8'hA5.
- Round-robin, all four requesting continuously from reset:
  - Grant order is 0,1,2,3,0,… with one grant every 2 cycles.
  - No bit of grant repeats within 8 cycles.
- Cancellation: requester 2 wins ARB, then drops req in ACCESS → grant=0, value unchanged, last unchanged. Next ARB with only req[2]=1 grants 2.
- Reset mid-access:
  - Requester 1 with we=1, wdata=8'h3C; reset asserted in its ACCESS cycle → no grant, value=7 afterwards.
  - Next arbitration with all requesting grants requester 0 first.
